// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit serializer feeding a programmable Moore-style pattern tracker with a
// saturating match counter and a sticky threshold interrupt.
module pattern_scan_ctrl #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              irq_clr,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              thresh_irq,
  output logic              busy
);

  localparam int unsigned IdxW = $clog2(WORD_W);
  localparam int unsigned HcW  = $clog2(PAT_W + 1);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(WORD_W - 1);
  localparam logic [HcW-1:0]   HcFull  = HcW'(PAT_W);
  localparam logic [PAT_W-1:0] PatRst  = PAT_W'(4'b1011);

  typedef enum logic {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;
  logic [CNT_W-1:0]  thr_q, thr_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [HcW-1:0]    hcnt_q, hcnt_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              irq_q, irq_d;

  logic              last_bit, accept, cfg_ok, hit, irq_set;
  logic [PAT_W:0]    hist_ext;
  logic [PAT_W-1:0]  hist_new;
  logic [HcW-1:0]    hcnt_new;
  logic [CNT_W-1:0]  cnt_inc;

  assign last_bit   = (state_q == StShift) && (idx_q == '0);
  assign in_ready   = (state_q == StIdle) || last_bit;
  assign busy       = (state_q == StShift);
  assign accept     = in_valid && in_ready;
  assign cfg_ok     = cfg_we && (state_q == StIdle) && !accept;
  assign match      = match_q;
  assign match_cnt  = cnt_q;
  assign thresh_irq = irq_q;

  // Extended by one bit so the shift also works for PAT_W == 1.
  assign hist_ext = {hist_q, shift_q[WORD_W-1]};
  assign hist_new = hist_ext[PAT_W-1:0];
  assign hcnt_new = (hcnt_q == HcFull) ? HcFull : hcnt_q + 1'b1;
  assign hit      = busy && (hist_new == pat_q) && (hcnt_new == HcFull);
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    thr_d   = thr_q;
    hist_d  = hist_q;
    hcnt_d  = hcnt_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    irq_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = in_data;
          idx_d   = IdxLast;
          state_d = StShift;
        end
      end
      StShift: begin
        shift_d = {shift_q[WORD_W-2:0], 1'b0};
        idx_d   = idx_q - 1'b1;
        hist_d  = hist_new;
        hcnt_d  = (hit && !ovl_q) ? '0 : hcnt_new;
        match_d = hit;
        // A saturated counter never re-arms the interrupt.
        if (hit && !(&cnt_q)) begin
          cnt_d   = cnt_inc;
          irq_set = (thr_q != '0) && (cnt_inc == thr_q);
        end
        if (last_bit) begin
          if (accept) begin
            shift_d = in_data;
            idx_d   = IdxLast;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (irq_set) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end

    if (cfg_ok) begin
      pat_d  = cfg_pattern;
      ovl_d  = cfg_overlap;
      thr_d  = cfg_thresh;
      hist_d = '0;
      hcnt_d = '0;
      cnt_d  = '0;
      irq_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      pat_q   <= PatRst;
      ovl_q   <= 1'b1;
      thr_q   <= '0;
      hist_q  <= '0;
      hcnt_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      thr_q   <= thr_d;
      hist_q  <= hist_d;
      hcnt_q  <= hcnt_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

endmodule
